vlsu_load_distributor: RTL and testbench

- Memory-side producer of the per-lane load write-back interface into the lane array (load_op_valid/gnt/data/strb/addr/id).
- Accepts one load command at a time, splits each wide memory response beat into NrLane VRF words, and holds each lane's word until that lane grants.
- Generates consecutive VRF addresses and applies the tail strobe on the final beat.
- Signals completion to the launcher once every lane has accepted the final beat.

---
 rtl/vlsu_load_distributor.sv | 148 ++++++++++++++
 tb/tb_vlsu_load_distributor.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vlsu_load_distributor.sv
// Load write-back distributor: splits each wide memory beat into one VRF word per lane
// and holds every word until its lane grants, then reports command completion.
module vlsu_load_distributor #(
  parameter int NrLane       = 4,
  parameter int VrfDataWidth = 64,
  parameter int VrfStrbWidth = VrfDataWidth / 8,
  parameter int VrfAddrWidth = 8,
  parameter int InsnIdWidth  = 3,
  parameter int BeatCntWidth = 9
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             cmd_valid_i,
  output logic                             cmd_ready_o,
  input  logic [InsnIdWidth-1:0]           cmd_id_i,
  input  logic [VrfAddrWidth-1:0]          cmd_base_addr_i,
  input  logic [BeatCntWidth-1:0]          cmd_nr_beats_i,
  input  logic [NrLane*VrfStrbWidth-1:0]   cmd_last_strb_i,
  input  logic                             mem_valid_i,
  output logic                             mem_ready_o,
  input  logic [NrLane*VrfDataWidth-1:0]   mem_data_i,
  output logic [NrLane-1:0]                load_op_valid_o,
  input  logic [NrLane-1:0]                load_op_gnt_i,
  output logic [NrLane*VrfDataWidth-1:0]   load_op_o,
  output logic [NrLane*VrfStrbWidth-1:0]   load_op_strb_o,
  output logic [NrLane*VrfAddrWidth-1:0]   load_op_addr_o,
  output logic [NrLane*InsnIdWidth-1:0]    load_id_o,
  output logic                             done_o,
  output logic [InsnIdWidth-1:0]           done_id_o
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_e;

  state_e                           state_q, state_d;
  logic [InsnIdWidth-1:0]           id_q, id_d;
  logic [VrfAddrWidth-1:0]          base_q, base_d;
  logic [BeatCntWidth-1:0]          nr_beats_q, nr_beats_d;
  logic [BeatCntWidth-1:0]          beat_idx_q, beat_idx_d;
  logic [NrLane*VrfStrbWidth-1:0]   last_strb_q, last_strb_d;
  logic [NrLane-1:0]                valid_q, valid_d;
  logic [NrLane*VrfDataWidth-1:0]   data_q, data_d;
  logic [NrLane*VrfStrbWidth-1:0]   strb_q, strb_d;
  logic [NrLane*VrfAddrWidth-1:0]   addr_q, addr_d;
  logic [NrLane*InsnIdWidth-1:0]    lid_q, lid_d;

  logic                             beats_left;
  logic                             all_free;
  logic                             beat_acc;
  logic                             final_beat;
  logic [VrfAddrWidth-1:0]          beat_addr;
  logic [VrfStrbWidth-1:0]          lane_strb;

  always_comb begin
    beats_left  = (beat_idx_q != nr_beats_q);
    all_free    = &(~valid_q | load_op_gnt_i);
    final_beat  = (beat_idx_q == (nr_beats_q - BeatCntWidth'(1)));
    beat_addr   = base_q + VrfAddrWidth'(beat_idx_q);
    // Grant feeds straight into ready so a fully granting array sustains one beat per cycle
    mem_ready_o = (state_q == ACTIVE) && beats_left && all_free;
    beat_acc    = mem_valid_i && mem_ready_o;
    cmd_ready_o = (state_q == IDLE);
    done_o      = (state_q == DONE);
    done_id_o   = id_q;

    state_d     = state_q;
    id_d        = id_q;
    base_d      = base_q;
    nr_beats_d  = nr_beats_q;
    beat_idx_d  = beat_idx_q;
    last_strb_d = last_strb_q;
    data_d      = data_q;
    strb_d      = strb_q;
    addr_d      = addr_q;
    lid_d       = lid_q;
    lane_strb   = '0;
    valid_d     = valid_q & ~load_op_gnt_i;

    if (beat_acc) begin
      beat_idx_d = beat_idx_q + BeatCntWidth'(1);
      for (int i = 0; i < NrLane; i++) begin
        lane_strb = final_beat ? last_strb_q[i*VrfStrbWidth +: VrfStrbWidth]
                               : {VrfStrbWidth{1'b1}};
        // A lane with an empty tail strobe is skipped entirely on the final beat
        if (|lane_strb) begin
          data_d[i*VrfDataWidth +: VrfDataWidth] = mem_data_i[i*VrfDataWidth +: VrfDataWidth];
          strb_d[i*VrfStrbWidth +: VrfStrbWidth] = lane_strb;
          addr_d[i*VrfAddrWidth +: VrfAddrWidth] = beat_addr;
          lid_d[i*InsnIdWidth +: InsnIdWidth]    = id_q;
          valid_d[i]                             = 1'b1;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          id_d        = cmd_id_i;
          base_d      = cmd_base_addr_i;
          nr_beats_d  = cmd_nr_beats_i;
          last_strb_d = cmd_last_strb_i;
          beat_idx_d  = '0;
          state_d     = (cmd_nr_beats_i == '0) ? DONE : ACTIVE;
        end
      end
      ACTIVE: begin
        // Looking at next-cycle valid lets final grants and completion coincide
        if (!beats_left && (valid_d == '0)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      id_q        <= '0;
      base_q      <= '0;
      nr_beats_q  <= '0;
      beat_idx_q  <= '0;
      last_strb_q <= '0;
      valid_q     <= '0;
      data_q      <= '0;
      strb_q      <= '0;
      addr_q      <= '0;
      lid_q       <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      base_q      <= base_d;
      nr_beats_q  <= nr_beats_d;
      beat_idx_q  <= beat_idx_d;
      last_strb_q <= last_strb_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      strb_q      <= strb_d;
      addr_q      <= addr_d;
      lid_q       <= lid_d;
    end
  end

  assign load_op_valid_o = valid_q;
  assign load_op_o       = data_q;
  assign load_op_strb_o  = strb_q;
  assign load_op_addr_o  = addr_q;
  assign load_id_o       = lid_q;

endmodule

// File: tb/tb_vlsu_load_distributor.sv
// Bench for vlsu_load_distributor: per-lane scoreboard filled on each accepted memory beat
// and drained on each lane transfer, plus directed timing checks around commands.
module tb_vlsu_load_distributor;
  localparam int NL = 4;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int AW = 8;
  localparam int IW = 3;
  localparam int BW = 9;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               cmd_valid_i;
  logic               cmd_ready_o;
  logic [IW-1:0]      cmd_id_i;
  logic [AW-1:0]      cmd_base_addr_i;
  logic [BW-1:0]      cmd_nr_beats_i;
  logic [NL*SW-1:0]   cmd_last_strb_i;
  logic               mem_valid_i;
  logic               mem_ready_o;
  logic [NL*DW-1:0]   mem_data_i;
  logic [NL-1:0]      load_op_valid_o;
  logic [NL-1:0]      load_op_gnt_i;
  logic [NL*DW-1:0]   load_op_o;
  logic [NL*SW-1:0]   load_op_strb_o;
  logic [NL*AW-1:0]   load_op_addr_o;
  logic [NL*IW-1:0]   load_id_o;
  logic               done_o;
  logic [IW-1:0]      done_id_o;

  always #5 clk_i = ~clk_i;

  vlsu_load_distributor #(
    .NrLane(NL), .VrfDataWidth(DW), .VrfStrbWidth(SW), .VrfAddrWidth(AW),
    .InsnIdWidth(IW), .BeatCntWidth(BW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_id_i(cmd_id_i),
    .cmd_base_addr_i(cmd_base_addr_i), .cmd_nr_beats_i(cmd_nr_beats_i),
    .cmd_last_strb_i(cmd_last_strb_i),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o), .mem_data_i(mem_data_i),
    .load_op_valid_o(load_op_valid_o), .load_op_gnt_i(load_op_gnt_i),
    .load_op_o(load_op_o), .load_op_strb_o(load_op_strb_o),
    .load_op_addr_o(load_op_addr_o), .load_id_o(load_id_o),
    .done_o(done_o), .done_id_o(done_id_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [AW-1:0] a;
    logic [IW-1:0] id;
  } word_t;

  word_t exp_q[NL][$];

  // Reference model state, owned by the monitor
  logic [AW-1:0]    m_base;
  logic [BW-1:0]    m_nb;
  logic [BW-1:0]    m_idx;
  logic [NL*SW-1:0] m_lstrb;
  logic [IW-1:0]    m_id;
  int               done_cnt = 0;

  // Memory source bookkeeping
  int beats_req  = 0;
  int beats_sent = 0;

  initial begin
    logic acc;
    mem_valid_i = 1'b0;
    mem_data_i  = '0;
    forever begin
      @(negedge clk_i);
      acc = mem_valid_i && mem_ready_o && !rst_i;
      @(posedge clk_i);
      #1;
      if (acc) beats_sent++;
      if (beats_sent < beats_req) begin
        if (acc || !mem_valid_i)
          for (int k = 0; k < NL*DW/32; k++) mem_data_i[k*32 +: 32] = $urandom;
        mem_valid_i = 1'b1;
      end else begin
        mem_valid_i = 1'b0;
      end
    end
  end

  always @(negedge clk_i) begin
    word_t            w;
    logic             fin;
    logic [SW-1:0]    s;
    int               pend;
    if (rst_i) begin
      for (int i = 0; i < NL; i++) exp_q[i].delete();
    end else begin
      for (int i = 0; i < NL; i++) begin
        if (load_op_valid_o[i] && load_op_gnt_i[i]) begin
          chk($sformatf("lane%0d_word_expected", i), 64'(exp_q[i].size() != 0), 64'd1);
          if (exp_q[i].size() != 0) begin
            w = exp_q[i].pop_front();
            chk($sformatf("lane%0d_data", i), load_op_o[i*DW +: DW], w.d);
            chk($sformatf("lane%0d_strb", i), 64'(load_op_strb_o[i*SW +: SW]), 64'(w.s));
            chk($sformatf("lane%0d_addr", i), 64'(load_op_addr_o[i*AW +: AW]), 64'(w.a));
            chk($sformatf("lane%0d_id", i), 64'(load_id_o[i*IW +: IW]), 64'(w.id));
          end
        end
      end
      if (cmd_valid_i && cmd_ready_o) begin
        m_base  = cmd_base_addr_i;
        m_nb    = cmd_nr_beats_i;
        m_lstrb = cmd_last_strb_i;
        m_id    = cmd_id_i;
        m_idx   = '0;
      end
      if (mem_valid_i && mem_ready_o) begin
        fin = (m_idx == m_nb - 1);
        for (int i = 0; i < NL; i++) begin
          s = fin ? m_lstrb[i*SW +: SW] : {SW{1'b1}};
          if (s != '0) begin
            w.d  = mem_data_i[i*DW +: DW];
            w.s  = s;
            w.a  = m_base + m_idx[AW-1:0];
            w.id = m_id;
            exp_q[i].push_back(w);
          end
        end
        m_idx = m_idx + 1;
      end
      if (done_o) begin
        pend = 0;
        for (int i = 0; i < NL; i++) pend += exp_q[i].size();
        chk("done_id", 64'(done_id_o), 64'(m_id));
        chk("done_words_drained", 64'(pend), 64'd0);
        done_cnt++;
      end
    end
  end

  task automatic send_cmd(input logic [IW-1:0] id, input logic [AW-1:0] base,
                          input logic [BW-1:0] nb, input logic [NL*SW-1:0] ls);
    int w = 0;
    @(posedge clk_i); #2;
    while (!cmd_ready_o && w < 50) begin
      @(posedge clk_i); #2;
      w++;
    end
    chk("cmd_ready_wait", 64'(cmd_ready_o), 64'd1);
    cmd_valid_i     = 1'b1;
    cmd_id_i        = id;
    cmd_base_addr_i = base;
    cmd_nr_beats_i  = nb;
    cmd_last_strb_i = ls;
    beats_req       = beats_req + int'(nb);
    @(posedge clk_i); #2;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit rnd_gnt, output int cyc);
    cyc = 0;
    while (!done_o && cyc < 300) begin
      @(posedge clk_i); #3;
      if (rnd_gnt) load_op_gnt_i = NL'($urandom);
      cyc++;
    end
    chk({tag, "_done_seen"}, 64'(done_o), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int               cyc;
    int               d0;
    logic [DW-1:0]    cap_d;
    logic [SW-1:0]    cap_s;
    logic [AW-1:0]    cap_a;

    rst_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_id_i = '0; cmd_base_addr_i = '0;
    cmd_nr_beats_i = '0; cmd_last_strb_i = '0; load_op_gnt_i = '0;
    repeat (3) @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    chk("rst_mem_ready", 64'(mem_ready_o), 64'd0);
    chk("rst_valid", 64'(load_op_valid_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_data", 64'(|load_op_o), 64'd0);
    chk("rst_addr", 64'(|load_op_addr_o), 64'd0);

    // Streaming: three beats, all lanes granting
    load_op_gnt_i = '1;
    d0 = done_cnt;
    send_cmd(3'd5, 8'h10, 9'd3, '1);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("t1_beat_accept", 64'(mem_valid_i && mem_ready_o), 64'd1);
      @(posedge clk_i); #3;
    end
    chk("t1_ready_after_last", 64'(mem_ready_o), 64'd0);
    wait_done("t1", 1'b0, cyc);
    chk("t1_done_latency", 64'(cyc), 64'd1);
    chk("t1_done_id_direct", 64'(done_id_o), 64'd5);
    repeat (3) @(posedge clk_i);
    #3;
    chk("t1_done_once", 64'(done_cnt - d0), 64'd1);

    // Lane 2 back-pressure during beat 0
    load_op_gnt_i = 4'b1011;
    send_cmd(3'd2, 8'h20, 9'd2, '1);
    @(posedge clk_i); #3;
    chk("t2_all_valid", 64'(load_op_valid_o), 64'hF);
    chk("t2_ready_blocked0", 64'(mem_ready_o), 64'd0);
    cap_d = load_op_o[2*DW +: DW];
    cap_s = load_op_strb_o[2*SW +: SW];
    cap_a = load_op_addr_o[2*AW +: AW];
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_i); #3;
      chk("t2_ready_blocked", 64'(mem_ready_o), 64'd0);
      chk("t2_valid_only_l2", 64'(load_op_valid_o), 64'h4);
      chk("t2_l2_data_stable", load_op_o[2*DW +: DW], cap_d);
      chk("t2_l2_strb_stable", 64'(load_op_strb_o[2*SW +: SW]), 64'(cap_s));
      chk("t2_l2_addr_stable", 64'(load_op_addr_o[2*AW +: AW]), 64'h20);
    end
    chk("t2_l2_addr_cap", 64'(cap_a), 64'h20);
    load_op_gnt_i = '1;
    wait_done("t2", 1'b0, cyc);

    // Tail strobes with two skipped lanes
    send_cmd(3'd3, 8'h30, 9'd2, {8'h00, 8'h00, 8'h0F, 8'hFF});
    wait_done("t3", 1'b0, cyc);

    // Zero-beat command
    d0 = done_cnt;
    send_cmd(3'd6, 8'h50, 9'd0, '1);
    #1;
    chk("t4_done_pulse", 64'(done_o), 64'd1);
    chk("t4_done_id", 64'(done_id_o), 64'd6);
    chk("t4_cmd_ready_in_done", 64'(cmd_ready_o), 64'd0);
    chk("t4_no_valid", 64'(load_op_valid_o), 64'd0);
    @(posedge clk_i); #3;
    chk("t4_done_clear", 64'(done_o), 64'd0);
    chk("t4_cmd_ready_back", 64'(cmd_ready_o), 64'd1);

    // Address wrap
    send_cmd(3'd1, 8'hFE, 9'd4, '1);
    wait_done("t5", 1'b0, cyc);

    // Reset with lanes 2 and 3 pending
    load_op_gnt_i = 4'b0011;
    send_cmd(3'd4, 8'h60, 9'd2, '1);
    @(posedge clk_i);
    @(posedge clk_i); #3;
    chk("t6_two_pending", 64'(load_op_valid_o), 64'hC);
    d0 = done_cnt;
    rst_i = 1'b1;
    beats_req = beats_sent;
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    #1;
    chk("t6_valid_cleared", 64'(load_op_valid_o), 64'd0);
    chk("t6_cmd_ready", 64'(cmd_ready_o), 64'd1);
    chk("t6_no_done", 64'(done_o), 64'd0);
    repeat (4) @(posedge clk_i);
    #3;
    chk("t6_no_done_count", 64'(done_cnt - d0), 64'd0);
    load_op_gnt_i = '1;
    send_cmd(3'd7, 8'h70, 9'd2, '1);
    wait_done("t6_after", 1'b0, cyc);

    // Random grant pattern with random tail strobes
    send_cmd(3'd2, 8'h80, 9'd6, NL*SW'({$urandom, $urandom}));
    wait_done("t7", 1'b1, cyc);
    load_op_gnt_i = '1;
    repeat (3) @(posedge clk_i);
    #3;
    for (int i = 0; i < NL; i++)
      chk($sformatf("final_lane%0d_drained", i), 64'(exp_q[i].size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
